shake_msg_packer: RTL and testbench

- Byte-stream to 64-bit lane packer that drives the message input side of the SHAKE absorb core: in_valid, in_data, is_last, byte_num.
- Packs bytes little-endian into Keccak lanes and marks the final lane with its unused-byte count.
- Tracks rate-block boundaries so upstream logic can align multi-block messages.
- Sits between the message source (DMA/byte FIFO) and the SHAKE core.

---
 rtl/shake_pkg.sv | 22 ++
 rtl/shake_msg_packer.sv | 189 ++++++++++++++++++
 tb/tb_shake_msg_packer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shake_pkg.sv
// Shared SHAKE definitions: lane width, rate constants, packer states.
// Ports: none (package only).
package shake_pkg;

  localparam int LANE_BITS     = 64;
  localparam int SHAKE128_RATE = 1344;
  localparam int SHAKE256_RATE = 1088;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_FLUSH = 2'd2
  } pkr_state_t;

  // Unused bytes in a final lane holding nb (1..8) bytes.
  function automatic logic [2:0] unused_bytes(
    input logic [3:0] nb
  );
    return 3'(4'd8 - nb);
  endfunction

endpackage

// File: rtl/shake_msg_packer.sv
// Byte stream to 64-bit little-endian Keccak lane packer for SHAKE absorb.
// Ports: clk, reset (sync, active high); byte side s_valid/s_data/s_last/
//   s_empty/s_ready; lane side m_valid/m_data/m_last/m_byte_num/m_empty/
//   m_block_end/m_ready. Optional msg_bytes[31:0] when the macro
//   SHAKE_PACK_BYTECNT_EN is defined.
module shake_msg_packer
  import shake_pkg::*;
#(
  parameter int RATE_BITS = SHAKE128_RATE,
  parameter int LANE_BITS = shake_pkg::LANE_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  input  logic                 s_empty,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic [LANE_BITS-1:0] m_data,
  output logic                 m_last,
  output logic [2:0]           m_byte_num,
  output logic                 m_empty,
  output logic                 m_block_end,
  input  logic                 m_ready
`ifdef SHAKE_PACK_BYTECNT_EN
  ,
  output logic [31:0]          msg_bytes
`endif
);

  localparam int LANES = RATE_BITS / LANE_BITS;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

  pkr_state_t           state;
  logic [LANE_BITS-1:0] acc;
  logic [2:0]           cnt;
  logic                 acc_full;
  logic                 acc_last;
  logic                 acc_empty;
  logic [2:0]           acc_byte_num;
  logic [LW-1:0]        lane_cnt;

  logic                 accept;
  logic                 drain;
  logic                 out_free;
  logic                 from_acc;
  logic                 fin;
  logic                 done;
  logic                 park;
  logic                 emp;
  logic                 be;
  logic [3:0]           nb;
  logic [2:0]           bn;
  logic [LW-1:0]        lane_nxt;
  logic [LANE_BITS-1:0] acc_base;
  logic [LANE_BITS-1:0] lane;

  assign s_ready = !(acc_full && m_valid && !m_ready)
                 && (state != S_FLUSH);

  assign accept   = s_valid && s_ready;
  assign drain    = m_valid && m_ready;
  assign out_free = !m_valid || drain;
  assign from_acc = acc_full && out_free;

  // A byte accepted while acc is full means acc is
  // vacating into the output register this cycle.
  assign acc_base = acc_full ? '0 : acc;

  always_comb begin
    lane = acc_base;
    if (!s_empty)
      lane = acc_base
           | (LANE_BITS'(s_data) << {cnt, 3'b000});
  end

  assign fin  = s_last || s_empty;
  assign done = accept && (fin || cnt == 3'd7);
  assign emp  = s_empty && (cnt == 3'd0);
  assign nb   = {1'b0, cnt} + {3'b000, !s_empty};
  assign bn   = (fin && !emp) ? unused_bytes(nb) : 3'd0;
  assign park = done && (!out_free || acc_full);

  // Lane position seen by the word loaded this cycle.
  assign lane_nxt = !drain ? lane_cnt
                  : (m_last || lane_cnt == LAST_LANE) ? '0
                  : lane_cnt + 1'b1;
  assign be = (lane_nxt == LAST_LANE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      acc          <= '0;
      cnt          <= '0;
      acc_full     <= 1'b0;
      acc_last     <= 1'b0;
      acc_empty    <= 1'b0;
      acc_byte_num <= '0;
      lane_cnt     <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      m_last       <= 1'b0;
      m_byte_num   <= '0;
      m_empty      <= 1'b0;
      m_block_end  <= 1'b0;
    end else begin
      if (drain) begin
        m_valid  <= 1'b0;
        lane_cnt <= lane_nxt;
      end

      if (from_acc) begin
        m_valid     <= 1'b1;
        m_data      <= acc;
        m_last      <= acc_last;
        m_byte_num  <= acc_byte_num;
        m_empty     <= acc_empty;
        m_block_end <= be;
      end else if (done && out_free) begin
        m_valid     <= 1'b1;
        m_data      <= lane;
        m_last      <= fin;
        m_byte_num  <= bn;
        m_empty     <= emp;
        m_block_end <= be;
      end

      if (accept) begin
        if (done) begin
          cnt <= '0;
          if (park) begin
            acc          <= lane;
            acc_full     <= 1'b1;
            acc_last     <= fin;
            acc_byte_num <= bn;
            acc_empty    <= emp;
          end else begin
            acc      <= '0;
            acc_full <= 1'b0;
          end
        end else begin
          acc      <= lane;
          cnt      <= cnt + 3'd1;
          acc_full <= 1'b0;
        end
      end else if (from_acc) begin
        acc      <= '0;
        acc_full <= 1'b0;
      end

      unique case (state)
        S_IDLE:
          if (accept)
            state <= fin ? S_FLUSH : S_FILL;
        S_FILL:
          if (accept && fin)
            state <= S_FLUSH;
        S_FLUSH:
          if (drain && m_last)
            state <= S_IDLE;
        default:
          state <= S_IDLE;
      endcase
    end
  end

`ifdef SHAKE_PACK_BYTECNT_EN
  logic [31:0] cur_bytes;

  // No byte can be accepted while the final word
  // is pending, so cur_bytes is exact at that point.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_bytes <= '0;
      msg_bytes <= '0;
    end else if (drain && m_last) begin
      msg_bytes <= cur_bytes;
      cur_bytes <= '0;
    end else if (accept && !s_empty) begin
      cur_bytes <= cur_bytes + 32'd1;
    end
  end
`else
  // Byte counter not built.
`endif

endmodule

// File: tb/tb_shake_msg_packer.sv
// Randomized self-checking bench for shake_msg_packer.
// Ports: none (top-level bench).
module tb_shake_msg_packer;

  localparam int RATE = 128;
  localparam int NL   = RATE / 64;

  typedef struct packed {
    logic [63:0] d;
    logic        last;
    logic [2:0]  bn;
    logic        emp;
    logic        be;
  } word_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        s_empty = 1'b0;
  logic        s_ready;
  logic        m_valid;
  logic [63:0] m_data;
  logic        m_last;
  logic [2:0]  m_byte_num;
  logic        m_empty;
  logic        m_block_end;
  logic        m_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int stab_err = 0;
  bit rdy_random = 1'b0;
  bit rdy_force = 1'b1;
  bit gaps = 1'b0;

  word_t obs_q[$];
  word_t exp_q[$];
  word_t held;
  bit    hold = 1'b0;

  shake_msg_packer #(.RATE_BITS(RATE)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_data(s_data),
    .s_last(s_last), .s_empty(s_empty),
    .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data),
    .m_last(m_last), .m_byte_num(m_byte_num),
    .m_empty(m_empty), .m_block_end(m_block_end),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = rdy_random ? ($urandom_range(0, 2) != 0)
                         : rdy_force;
  end

  always @(negedge clk) begin
    word_t cur;
    cur = {m_data, m_last, m_byte_num, m_empty, m_block_end};
    if (!reset && m_valid && m_ready) obs_q.push_back(cur);
    if (!reset && hold && (!m_valid || cur !== held))
      stab_err++;
    hold = !reset && m_valid && !m_ready;
    held = cur;
  end

  // Expected words from message bytes: little-endian
  // lanes, zero padding, rate block position per word.
  task automatic model_msg(input logic [7:0] b[$]);
    int n = b.size();
    int nw = (n == 0) ? 1 : (n + 7) / 8;
    int lane = 0;
    word_t e;
    for (int w = 0; w < nw; w++) begin
      e = '0;
      for (int k = 0; k < 8; k++)
        if (w * 8 + k < n) e.d[8*k +: 8] = b[w*8 + k];
      e.last = (w == nw - 1);
      e.emp  = (n == 0);
      e.bn   = (e.last && n != 0)
             ? 3'((8 - (n - w * 8)) % 8) : 3'd0;
      e.be   = (lane == NL - 1);
      lane   = (e.last || e.be) ? 0 : lane + 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_msg(input logic [7:0] b[$]);
    int n = b.size();
    int beats = (n == 0) ? 1 : n;
    int i = 0;
    int guard = 0;
    while (i < beats) begin
      guard++;
      if (guard > 5000) begin
        errors++;
        $display("FAIL send_timeout sent %0d need %0d", i, beats);
        break;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        continue;
      end
      s_valid = 1'b1;
      s_empty = (n == 0);
      s_data  = (n == 0) ? 8'($urandom) : b[i];
      s_last  = (i == beats - 1);
      @(negedge clk);
      if (s_ready) i++;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_empty = 1'b0;
  endtask

  task automatic wait_words(input int want);
    int t = 0;
    while (obs_q.size() < want && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL rst_m_valid got %b want 0", m_valid);
    end
    checks++;
    if (m_data !== 64'h0) begin
      errors++; $display("FAIL rst_m_data got %h want 0", m_data);
    end
    checks++;
    if (m_last !== 1'b0) begin
      errors++; $display("FAIL rst_m_last got %b want 0", m_last);
    end
    checks++;
    if (m_byte_num !== 3'd0) begin
      errors++; $display("FAIL rst_byte_num got %0d want 0", m_byte_num);
    end
    checks++;
    if (m_empty !== 1'b0) begin
      errors++; $display("FAIL rst_m_empty got %b want 0", m_empty);
    end
    checks++;
    if (m_block_end !== 1'b0) begin
      errors++; $display("FAIL rst_block_end got %b want 0", m_block_end);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL rst_s_ready got %b want 1", s_ready);
    end
  endtask

  task automatic test_abc();
    logic [7:0] b[$];
    word_t e, o;
    b = '{8'h61, 8'h62, 8'h63};
    model_msg(b);
    send_msg(b);
    wait_words(exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL abc missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL abc word got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL abc extra got %0d want 0", obs_q.size());
    end
  endtask

  task automatic test_full_lane();
    logic [7:0] b[$];
    word_t e, o;
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i <= 8; i++) b.push_back(8'(i));
    model_msg(b);
    send_msg(b);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_hold got rdy %b vld %b want 0 1", s_ready, m_valid);
    end
    rdy_force = 1'b1;
    wait_words(exp_q.size());
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL full_reopen got %b want 1", s_ready);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL full missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL full word got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL full extra got %0d want 0", obs_q.size());
    end
  endtask

  task automatic test_empty_and_rate();
    logic [7:0] b[$];
    logic [7:0] z[$];
    word_t e, o;
    model_msg(z);
    send_msg(z);
    for (int i = 0; i < 20; i++) b.push_back(8'(i));
    model_msg(b);
    send_msg(b);
    wait_words(exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL rate missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL rate word got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL rate extra got %0d want 0", obs_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] b[$];
    logic [7:0] rest[$];
    word_t e, o;
    int n = 0;
    rdy_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) b.push_back(8'($urandom));
    model_msg(b);
    for (int c = 0; c < 40; c++) begin
      s_valid = 1'b1;
      s_data  = b[n];
      s_last  = 1'b0;
      @(negedge clk);
      if (!s_ready) break;
      n++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL bp_accepted got %0d want 16", n);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL bp_stall got %b want 0", s_ready);
    end
    rdy_force = 1'b1;
    rest = b[n:$];
    send_msg(rest);
    wait_words(exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL bp missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL bp word got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL bp extra got %0d want 0", obs_q.size());
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL bp_stable got %0d want 0", stab_err);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] b[$];
    word_t e, o;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      s_last  = 1'b0;
      @(posedge clk);
      #1;
    end
    do_reset();
    b = '{8'h61, 8'h62, 8'h63};
    model_msg(b);
    send_msg(b);
    wait_words(exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL abort missing got none want %h", e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL abort word got %h want %h", o, e);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL abort extra got %0d want 0", obs_q.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] b[$];
    word_t e, o;
    int idx = 0;
    gaps = 1'b1;
    rdy_random = 1'b1;
    for (int m = 0; m < 30; m++) begin
      b.delete();
      for (int i = 0; i < $urandom_range(0, 30); i++)
        b.push_back(8'($urandom));
      model_msg(b);
      send_msg(b);
    end
    wait_words(exp_q.size());
    rdy_random = 1'b0;
    gaps = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL rnd missing %0d got none want %h", idx, e);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++; $display("FAIL rnd word %0d got %h want %h", idx, o, e);
        end
      end
      idx++;
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL rnd extra got %0d want 0", obs_q.size());
    end
    checks++;
    if (stab_err != 0) begin
      errors++; $display("FAIL rnd_stable got %0d want 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_full_lane();
    test_empty_and_rate();
    test_backpressure();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
